// File: rtl/dp_vector_pkg.sv
// Shared types and elaboration-time helpers for the dot-product engine.
package dp_vector_pkg;

  // Control states of the fetch / multiply-accumulate sequencer.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR_A = 3'd1,
    ST_R_A  = 3'd2,
    ST_AR_B = 3'd3,
    ST_R_B  = 3'd4,
    ST_MAC  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  // Bytes carried by one memory beat.
  function automatic int bytes_per_beat(input int lanes, input int data_w);
    return (lanes * data_w) / 8;
  endfunction

  // ceil(log2(lanes)): growth of a lane sum over a single product.
  function automatic int lane_bits(input int lanes);
    int b;
    b = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < lanes) begin
        b = i + 1;
      end
    end
    return b;
  endfunction

  // Legal parameter set: byte-multiple elements, power-of-two lanes and an
  // accumulator wide enough that a single lane sum can never overflow.
  function automatic bit params_legal(input int lanes, input int data_w, input int acc_w);
    return (data_w > 0) && ((data_w % 8) == 0) && (lanes >= 1) &&
           ((lanes & (lanes - 1)) == 0) &&
           (acc_w >= (2 * data_w) + lane_bits(lanes));
  endfunction

endpackage

// File: rtl/dp_lane_sum.sv
// Masked LANES-way multiply and adder tree for one A/B beat pair.
// Lanes at or beyond 'remaining' contribute zero (partial last beat).
module dp_lane_sum
  import dp_vector_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 16
) (
  input  logic [LANES*DATA_W-1:0] a_beat,
  input  logic [LANES*DATA_W-1:0] b_beat,
  input  logic [LEN_W-1:0]        remaining,
  input  logic                    signed_mode,
  output logic [ACC_W-1:0]        sum
);

  logic [ACC_W-1:0] ext_s [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0]          a_e_s;
    logic [DATA_W-1:0]          b_e_s;
    logic signed [2*DATA_W-1:0] prod_sg_s;
    logic [2*DATA_W-1:0]        prod_us_s;
    logic [ACC_W-1:0]           wide_sg_s;
    logic [ACC_W-1:0]           wide_us_s;

    assign a_e_s     = a_beat[i*DATA_W +: DATA_W];
    assign b_e_s     = b_beat[i*DATA_W +: DATA_W];
    assign prod_sg_s = $signed(a_e_s) * $signed(b_e_s);
    assign prod_us_s = a_e_s * b_e_s;
    // Size casts keep signedness, so the signed product is sign-extended.
    assign wide_sg_s = ACC_W'(prod_sg_s);
    assign wide_us_s = ACC_W'(prod_us_s);
    assign ext_s[i]  = (remaining > LEN_W'(i)) ?
                       (signed_mode ? wide_sg_s : wide_us_s) : {ACC_W{1'b0}};
  end

  // Adder tree over the masked, extended lane products.
  always_comb begin
    sum = {ACC_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      sum = sum + ext_s[i];
    end
  end

endmodule

// File: rtl/dp_vector_engine.sv
// Dot-product engine: fetches A and B beat by beat over a single-outstanding
// read channel and multiply-accumulates them into a wrapping accumulator
// with a sticky overflow flag.
module dp_vector_engine
  import dp_vector_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_a,
  input  logic [ADDR_W-1:0]       base_b,
  input  logic [LEN_W-1:0]        length,
  input  logic                    signed_mode,
  output logic [ADDR_W-1:0]       MEM_ARADDR,
  output logic                    MEM_ARVALID,
  input  logic                    MEM_ARREADY,
  input  logic [LANES*DATA_W-1:0] MEM_RDATA,
  input  logic                    MEM_RVALID,
  output logic                    MEM_RREADY,
  output logic                    busy,
  output logic                    done,
  output logic [ACC_W-1:0]        result,
  output logic                    overflow
);

  localparam int                BPB       = bytes_per_beat(LANES, DATA_W);
  localparam logic [ADDR_W-1:0] BPB_ADDR  = ADDR_W'(BPB);
  localparam logic [LEN_W-1:0]  LANES_LEN = LEN_W'(LANES);

  if (!params_legal(LANES, DATA_W, ACC_W)) begin : g_illegal_params
    $error("dp_vector_engine: illegal LANES/DATA_W/ACC_W combination");
  end

  state_t                  state_r, state_next_s;
  logic [ADDR_W-1:0]       base_a_r, base_b_r, offset_r, araddr_r;
  logic [LEN_W-1:0]        remaining_r, rem_dec_s;
  logic                    signed_r;
  logic [LANES*DATA_W-1:0] a_beat_r, b_beat_r;
  logic [ACC_W-1:0]        acc_r, result_r, lane_sum_s, acc_sum_s;
  logic [ACC_W:0]          acc_wide_s;
  logic                    ovf_s, overflow_r;
  logic                    arvalid_r, rready_r, busy_r, done_r;
  logic                    last_beat_s;

  dp_lane_sum #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) u_lane_sum (
    .a_beat     (a_beat_r),
    .b_beat     (b_beat_r),
    .remaining  (remaining_r),
    .signed_mode(signed_r),
    .sum        (lane_sum_s)
  );

  // Accumulate step: wrapped sum, overflow detect and remaining-count update.
  always_comb begin
    acc_wide_s  = {1'b0, acc_r} + {1'b0, lane_sum_s};
    acc_sum_s   = acc_wide_s[ACC_W-1:0];
    last_beat_s = (remaining_r <= LANES_LEN);
    if (signed_r) begin
      ovf_s = (acc_r[ACC_W-1] == lane_sum_s[ACC_W-1]) &&
              (acc_sum_s[ACC_W-1] != acc_r[ACC_W-1]);
    end else begin
      ovf_s = acc_wide_s[ACC_W];
    end
    if (last_beat_s) begin
      rem_dec_s = {LEN_W{1'b0}};
    end else begin
      rem_dec_s = remaining_r - LANES_LEN;
    end
  end

  // Next-state logic of the fetch / MAC sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = (length == {LEN_W{1'b0}}) ? ST_DONE : ST_AR_A;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_AR_A: begin
        if (MEM_ARREADY) state_next_s = ST_R_A;
        else             state_next_s = ST_AR_A;
      end
      ST_R_A: begin
        if (MEM_RVALID) state_next_s = ST_AR_B;
        else            state_next_s = ST_R_A;
      end
      ST_AR_B: begin
        if (MEM_ARREADY) state_next_s = ST_R_B;
        else             state_next_s = ST_AR_B;
      end
      ST_R_B: begin
        if (MEM_RVALID) state_next_s = ST_MAC;
        else            state_next_s = ST_R_B;
      end
      ST_MAC: begin
        if (last_beat_s) state_next_s = ST_DONE;
        else             state_next_s = ST_AR_A;
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register, registered handshake/status outputs and datapath.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r     <= ST_IDLE;
      base_a_r    <= {ADDR_W{1'b0}};
      base_b_r    <= {ADDR_W{1'b0}};
      offset_r    <= {ADDR_W{1'b0}};
      araddr_r    <= {ADDR_W{1'b0}};
      remaining_r <= {LEN_W{1'b0}};
      signed_r    <= 1'b0;
      a_beat_r    <= {(LANES*DATA_W){1'b0}};
      b_beat_r    <= {(LANES*DATA_W){1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      result_r    <= {ACC_W{1'b0}};
      overflow_r  <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      // Outputs are registered from the next state so they align with it.
      arvalid_r <= (state_next_s == ST_AR_A) || (state_next_s == ST_AR_B);
      rready_r  <= (state_next_s == ST_R_A) || (state_next_s == ST_R_B);
      busy_r    <= (state_next_s != ST_IDLE);
      done_r    <= (state_next_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            base_a_r    <= base_a;
            base_b_r    <= base_b;
            signed_r    <= signed_mode;
            remaining_r <= length;
            offset_r    <= {ADDR_W{1'b0}};
            araddr_r    <= base_a;
            acc_r       <= {ACC_W{1'b0}};
            result_r    <= {ACC_W{1'b0}};
            overflow_r  <= 1'b0;
          end
        end
        ST_R_A: begin
          if (MEM_RVALID) begin
            a_beat_r <= MEM_RDATA;
            araddr_r <= base_b_r + offset_r;
          end
        end
        ST_R_B: begin
          if (MEM_RVALID) begin
            b_beat_r <= MEM_RDATA;
          end
        end
        ST_MAC: begin
          acc_r       <= acc_sum_s;
          overflow_r  <= overflow_r | ovf_s;
          remaining_r <= rem_dec_s;
          offset_r    <= offset_r + BPB_ADDR;
          araddr_r    <= base_a_r + offset_r + BPB_ADDR;
          if (last_beat_s) begin
            result_r <= acc_sum_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign MEM_ARADDR  = araddr_r;
  assign MEM_ARVALID = arvalid_r;
  assign MEM_RREADY  = rready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign result      = result_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_dp_vector_engine.sv
// Directed self-checking bench for dp_vector_engine (default and ACC_W=18).
module tb_dp_vector_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic [31:0] base_a, base_b;
  logic [15:0] length;
  logic        signed_mode;
  logic        stall_en = 1'b0;

  logic [31:0] araddr0, araddr1;
  logic        arvalid0, arvalid1, arready0, arready1;
  logic [31:0] rdata0, rdata1;
  logic        rvalid0, rvalid1, rready0, rready1;
  logic        busy0, busy1, done0, done1, ovf0, ovf1;
  logic [31:0] result0;
  logic [17:0] result1;

  logic [7:0]  mem [0:255];
  logic [31:0] addr_q [$];

  int checks   = 0;
  int failures = 0;
  int cyc, first_ar, done_cyc, ndone;

  always #5 clk = ~clk;

  dp_vector_engine dut (
    .ACLK(clk), .ARESETN(rst_n), .start(start0), .base_a(base_a), .base_b(base_b),
    .length(length), .signed_mode(signed_mode), .MEM_ARADDR(araddr0),
    .MEM_ARVALID(arvalid0), .MEM_ARREADY(arready0), .MEM_RDATA(rdata0),
    .MEM_RVALID(rvalid0), .MEM_RREADY(rready0), .busy(busy0), .done(done0),
    .result(result0), .overflow(ovf0)
  );

  dp_vector_engine #(.ACC_W(18)) dut18 (
    .ACLK(clk), .ARESETN(rst_n), .start(start1), .base_a(base_a), .base_b(base_b),
    .length(length), .signed_mode(signed_mode), .MEM_ARADDR(araddr1),
    .MEM_ARVALID(arvalid1), .MEM_ARREADY(arready1), .MEM_RDATA(rdata1),
    .MEM_RVALID(rvalid1), .MEM_RREADY(rready1), .busy(busy1), .done(done1),
    .result(result1), .overflow(ovf1)
  );

  // Memory responders: one read outstanding, optional random stalls.
  logic        pend0 = 1'b0, pend1 = 1'b0;
  logic [31:0] paddr0 = 32'd0, paddr1 = 32'd0;
  logic        arg0 = 1'b1, rg0 = 1'b1, arg1 = 1'b1, rg1 = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else begin
      if (arvalid0 && arready0) begin pend0 <= 1'b1; paddr0 <= araddr0; end
      else if (rvalid0 && rready0) pend0 <= 1'b0;
      if (arvalid1 && arready1) begin pend1 <= 1'b1; paddr1 <= araddr1; end
      else if (rvalid1 && rready1) pend1 <= 1'b0;
    end
  end

  always @(posedge clk) begin
    arg0 <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    rg0  <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    arg1 <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    rg1  <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rst_n && arvalid0 && arready0) addr_q.push_back(araddr0);
  end

  assign arready0 = !pend0 && arg0;
  assign rvalid0  = pend0 && rg0;
  assign rdata0   = {mem[paddr0[7:0] + 8'd3], mem[paddr0[7:0] + 8'd2],
                     mem[paddr0[7:0] + 8'd1], mem[paddr0[7:0]]};
  assign arready1 = !pend1 && arg1;
  assign rvalid1  = pend1 && rg1;
  assign rdata1   = {mem[paddr1[7:0] + 8'd3], mem[paddr1[7:0] + 8'd2],
                     mem[paddr1[7:0] + 8'd1], mem[paddr1[7:0]]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // An address offered but not yet accepted must stay valid and unchanged.
  logic        hold_v = 1'b0;
  logic [31:0] hold_a = 32'd0;
  always @(negedge clk) begin
    if (hold_v && rst_n) begin
      chk("ar_hold_valid", {63'd0, arvalid0}, 64'd1);
      chk("ar_hold_addr", {32'd0, araddr0}, {32'd0, hold_a});
    end
    hold_v = rst_n && arvalid0 && !arready0;
    hold_a = araddr0;
  end

  // One operation; records first ARVALID cycle, done cycle and done pulses.
  task automatic run(input bit which, input logic [31:0] ba, input logic [31:0] bb,
                     input logic [15:0] len, input bit sm, input int poke_cyc);
    @(negedge clk);
    base_a = ba; base_b = bb; length = len; signed_mode = sm;
    addr_q.delete();
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    base_a = '1; base_b = '1; length = '1; signed_mode = ~sm;
    cyc = 1; first_ar = 0; done_cyc = 0; ndone = 0;
    for (int k = 0; k < 400; k++) begin
      start0 = 1'b0; start1 = 1'b0;
      if ((which ? arvalid1 : arvalid0) && first_ar == 0) first_ar = cyc;
      if (which ? done1 : done0) begin
        ndone++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (poke_cyc == cyc) begin
        if (which) start1 = 1'b1; else start0 = 1'b1;
      end
      if (done_cyc != 0 && cyc >= done_cyc + 6) break;
      @(posedge clk); #1;
      cyc++;
    end
    start0 = 1'b0; start1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    base_a = 32'd0; base_b = 32'd0; length = 16'd0; signed_mode = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    for (int i = 0; i < 4; i++) begin
      mem[8'h00 + i] = 8'(i + 1);
      mem[8'h10 + i] = 8'(i + 5);
      mem[8'h20 + i] = 8'hFF;
      mem[8'h24 + i] = 8'h02;
    end
    for (int i = 0; i < 8; i++) begin
      mem[8'h40 + i] = 8'(i + 1);
      mem[8'h50 + i] = 8'h01;
      mem[8'h80 + i] = 8'hFF;
    end

    // Reset state
    #12;
    chk("rst_arvalid", {63'd0, arvalid0}, 64'd0);
    chk("rst_rready", {63'd0, rready0}, 64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_done", {63'd0, done0}, 64'd0);
    chk("rst_result", {32'd0, result0}, 64'd0);
    chk("rst_ovf", {62'd0, ovf1, ovf0}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Unsigned single beat: 1*5+2*6+3*7+4*8 = 70
    run(1'b0, 32'h00, 32'h10, 16'd4, 1'b0, 0);
    chk("t1_result", {32'd0, result0}, 64'd70);
    chk("t1_ovf", {63'd0, ovf0}, 64'd0);
    chk("t1_done_cyc", 64'(done_cyc), 64'd6);
    chk("t1_first_ar", 64'(first_ar), 64'd1);
    chk("t1_ndone", 64'(ndone), 64'd1);
    chk("t1_busy_after", {63'd0, busy0}, 64'd0);
    chk("t1_nreq", 64'(addr_q.size()), 64'd2);
    if (addr_q.size() == 2) begin
      chk("t1_addr0", {32'd0, addr_q[0]}, 64'h00);
      chk("t1_addr1", {32'd0, addr_q[1]}, 64'h10);
    end

    // Signed: 4 * (-1 * 2) = -8 ; unsigned: 4 * 255 * 2 = 2040
    run(1'b0, 32'h20, 32'h24, 16'd4, 1'b1, 0);
    chk("t2_signed", {32'd0, result0}, 64'hFFFF_FFF8);
    chk("t2_signed_ovf", {63'd0, ovf0}, 64'd0);
    run(1'b0, 32'h20, 32'h24, 16'd4, 1'b0, 0);
    chk("t2_unsigned", {32'd0, result0}, 64'd2040);

    // Partial last beat: 1+2+...+6 = 21, two beats
    run(1'b0, 32'h40, 32'h50, 16'd6, 1'b0, 0);
    chk("t3_result", {32'd0, result0}, 64'd21);
    chk("t3_done_cyc", 64'(done_cyc), 64'd11);
    chk("t3_nreq", 64'(addr_q.size()), 64'd4);
    if (addr_q.size() == 4) begin
      chk("t3_addr0", {32'd0, addr_q[0]}, 64'h40);
      chk("t3_addr1", {32'd0, addr_q[1]}, 64'h50);
      chk("t3_addr2", {32'd0, addr_q[2]}, 64'h44);
      chk("t3_addr3", {32'd0, addr_q[3]}, 64'h54);
    end

    // Zero length: done in cycle 1, no traffic, result cleared
    run(1'b0, 32'h00, 32'h10, 16'd0, 1'b0, 0);
    chk("t4_done_cyc", 64'(done_cyc), 64'd1);
    chk("t4_first_ar", 64'(first_ar), 64'd0);
    chk("t4_nreq", 64'(addr_q.size()), 64'd0);
    chk("t4_result", {32'd0, result0}, 64'd0);

    // start while busy is ignored
    run(1'b0, 32'h00, 32'h10, 16'd4, 1'b0, 3);
    chk("t4b_ndone", 64'(ndone), 64'd1);
    chk("t4b_done_cyc", 64'(done_cyc), 64'd6);
    chk("t4b_result", {32'd0, result0}, 64'd70);

    // ACC_W=18: 8 * 255 * 255 = 520200 -> 258056, overflow
    run(1'b1, 32'h80, 32'h80, 16'd8, 1'b0, 0);
    chk("t5_result", {46'd0, result1}, 64'd258056);
    chk("t5_ovf", {63'd0, ovf1}, 64'd1);
    chk("t5_done_cyc", 64'(done_cyc), 64'd11);
    run(1'b1, 32'h00, 32'h10, 16'd4, 1'b0, 0);
    chk("t5_next_result", {46'd0, result1}, 64'd70);
    chk("t5_next_ovf", {63'd0, ovf1}, 64'd0);

    // Random handshake stalls
    stall_en = 1'b1;
    run(1'b0, 32'h40, 32'h50, 16'd6, 1'b0, 0);
    chk("t6_result", {32'd0, result0}, 64'd21);
    chk("t6_ndone", 64'(ndone), 64'd1);
    run(1'b0, 32'h20, 32'h24, 16'd4, 1'b1, 0);
    chk("t6_signed", {32'd0, result0}, 64'hFFFF_FFF8);
    stall_en = 1'b0;
    repeat (3) @(posedge clk);

    // Reset while in R_B, then a normal run
    @(negedge clk);
    base_a = 32'h00; base_b = 32'h10; length = 16'd4; signed_mode = 1'b0;
    start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("t7_in_rb", {63'd0, rready0}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_arvalid", {63'd0, arvalid0}, 64'd0);
    chk("t7_rready", {63'd0, rready0}, 64'd0);
    chk("t7_busy", {63'd0, busy0}, 64'd0);
    chk("t7_done", {63'd0, done0}, 64'd0);
    chk("t7_result", {32'd0, result0}, 64'd0);
    chk("t7_ovf", {63'd0, ovf0}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run(1'b0, 32'h00, 32'h10, 16'd4, 1'b0, 0);
    chk("t7_after_result", {32'd0, result0}, 64'd70);
    chk("t7_after_done_cyc", 64'(done_cyc), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dp_vector_engine.md
# dp_vector_engine

Parametrised next-generation dot-product engine. It fetches two vectors from byte-addressed memory over an AXI-style read channel, LANES elements per beat, and multiply-accumulates them into a wide accumulator. It supports signed or unsigned mode, a sticky overflow flag and arbitrary vector length including a partial last beat. It sits beside the AXI master and memory in the system top, driven by configuration-register values (bases, length, mode) and a start pulse.

## Interface
- LANES, 4, elements per memory beat (power of two, ≥1)
- DATA_W, 8, element width in bits (multiple of 8)
- ACC_W, 32, accumulator/result width (≥ 2·DATA_W)
- ADDR_W, 32, memory address width
- LEN_W, 16, vector-length field width (elements)
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- base_a, base_b  in  ADDR_W  byte address of element 0 of A / B; LANES·DATA_W/8-aligned
- length  in  LEN_W  element count; 0 is legal
- signed_mode  in  1  1 = two's-complement elements and accumulator
- MEM_ARADDR  out  ADDR_W  read address
- MEM_ARVALID  out  1  address valid
- MEM_ARREADY  in  1  address accepted
- MEM_RDATA  in  LANES·DATA_W  beat data; lane 0 = bits [DATA_W-1:0] = lowest address
- MEM_RVALID  in  1  data valid
- MEM_RREADY  out  1  data accept
- busy  out  1  high from the cycle after accepted start through DONE
- done  out  1  one-cycle completion pulse
- result  out  ACC_W  final sum; held until next accepted start
- overflow  out  1  sticky overflow of the current/last run

## Operation
- States: IDLE, AR_A, R_A, AR_B, R_B, MAC, DONE.
- IDLE + start: latch base_a, base_b, length and signed_mode. Clear acc, overflow and result. Set remaining = length and beat index = 0. If length = 0 go to DONE, else go to AR_A.
- AR_A: MEM_ARADDR = base_a + idx·BPB (BPB = LANES·DATA_W/8). MEM_ARVALID = 1 and stays high, with address stable, until MEM_ARREADY; then go to R_A.
- R_A: MEM_RREADY = 1. On MEM_RVALID capture the A beat, then go to AR_B. AR_B and R_B are identical using base_b; R_B then goes to MAC.
- MAC (one cycle):
  - lane i contributes a_i·b_i if i < remaining, else 0;
  - products are 2·DATA_W wide, sign- or zero-extended to ACC_W per signed_mode;
  - acc ← acc + lane sum;
  - remaining ← remaining − min(remaining, LANES); idx ← idx+1;
  - if remaining becomes 0 go to DONE, else go to AR_A.
- Overflow: set when a MAC add overflows ACC_W (signed: sign overflow; unsigned: carry-out). Lane-sum overflow is impossible given ACC_W ≥ 2·DATA_W + log2(LANES); ACC_W smaller than this is illegal. The accumulator wraps modulo 2^ACC_W. Overflow stays set until the next accepted start.
- DONE (one cycle): result ← acc, done = 1, then go to IDLE.
- start outside IDLE is ignored. Inputs change freely after acceptance.
- At most one read outstanding. ARVALID is never asserted in R_* states; RREADY is low outside R_* states.
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset (async, any state): state = IDLE; MEM_ARVALID, MEM_RREADY, busy, done and overflow = 0; result = 0; acc = 0. A read in flight is abandoned. The first start after reset release behaves normally.
- Zero-wait memory (ARREADY high, RVALID in the cycle after AR handshake):
  - 5 cycles per beat;
  - with start high at edge 0, ARVALID is first high in cycle 1;
  - done is high in cycle 5·W+1, where W = ceil(length/LANES);
  - length = 0: done is high in cycle 1, no memory traffic.
- Each ARREADY or RVALID stall cycle adds exactly one cycle.
- busy falls in the cycle after done; a new start is accepted in that same cycle.

## Structure
- Package dp_vector_pkg: state enum, BPB and lane-count localparam functions, and a parameter legality check (ACC_W bound, DATA_W % 8).
- Sub-module dp_lane_sum: combinational masked LANES-way multiply and adder tree. Inputs: A beat, B beat, remaining, signed_mode. Output: ACC_W sum. The FSM, address generation and accumulator live in the top.

## Test plan
- Default params, unsigned, length=4, A=1,2,3,4, B=5,6,7,8 -> one beat each, result=70, overflow=0, done at cycle 6.
- Signed, length=4, A=0xFF×4, B=0x02×4 -> result=0xFFFF_FFF8; same data unsigned -> result=2040.
- length=6, A=1..8, B all 1 -> 2 beats, lanes 2–3 of beat 2 masked, result=21, ARADDR sequence base_a, base_b, base_a+4, base_b+4.
- length=0 -> no ARVALID, done in cycle 1, result=0; start asserted while busy -> ignored, single done pulse.
- ACC_W=18, unsigned, length=8, all elements 0xFF -> 520200 mod 2^18 = 258056, overflow=1; the next run with small data clears overflow.
- Random ARREADY/RVALID stalls -> identical results, address held while ARVALID is high. ARESETN low during R_B -> all outputs 0 at once; the next start computes correctly.
